move_exec: RTL and testbench

//  Multi-cycle puzzle-move executor; sits directly upstream of the 16x28 register file and is its write-side master.
//  On a start pulse it reads the board (r0) and blank position (r2), swaps two 4-bit tiles, then writes back board, position,

---
 rtl/move_exec_if.sv | 26 ++
 rtl/move_exec.sv | 148 ++++++++++++++
 tb/tb_move_exec.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_exec_if.sv
// Register-file write-side bus of the move executor plus its start/status handshake.
interface move_exec_if #(parameter int W = 28);
  logic         start;
  logic [1:0]   dir;
  logic         busy;
  logic         done;
  logic         err;
  logic         solved;
  logic [3:0]   src0;
  logic [3:0]   src1;
  logic [W-1:0] data0;
  logic [W-1:0] data1;
  logic         we;
  logic [3:0]   dst;
  logic [W-1:0] data;

  modport master (
    input  start, dir, data0, data1,
    output busy, done, err, solved, src0, src1, we, dst, data
  );

  modport slave (
    output start, dir, data0, data1,
    input  busy, done, err, solved, src0, src1, we, dst, data
  );
endinterface

// File: rtl/move_exec.sv
// Puzzle-move executor: reads board/blank position, swaps two tiles, writes board, position, counter, solved flag.
// Latency: done 6 cycles after start (2 if the move is illegal); no backpressure, one write per cycle.
module move_exec #(
  parameter int         W       = 28,
  parameter int         NSLOT   = 7,
  parameter int         STRIDE  = 3,
  parameter logic [3:0] R_BOARD = 4'd0,
  parameter logic [3:0] R_IDEAL = 4'd1,
  parameter logic [3:0] R_PLACE = 4'd2,
  parameter logic [3:0] R_CNT   = 4'd7,
  parameter logic [3:0] R_COMP  = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  move_exec_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, SWAP, WPOS, WCNT, CMP, DONE, ERR} state_t;

  localparam logic [3:0] NS4 = 4'(NSLOT);
  localparam logic [3:0] ST4 = 4'(STRIDE);
  localparam logic [2:0] ST3 = 3'(STRIDE);

  state_t     state;
  logic [1:0] dir_q;
  logic [2:0] tgt_q;
  logic [2:0] pos3;
  logic [3:0] pos4;
  logic [2:0] tgt3;
  logic       illegal;
  logic       eq;

  assign pos3 = bus.data1[2:0];
  assign pos4 = {1'b0, pos3};
  assign eq   = (bus.data0 == bus.data1);

  // Legality uses 4-bit arithmetic so pos+STRIDE cannot wrap; tgt is only kept when legal.
  always_comb begin
    illegal = 1'b0;
    tgt3    = pos3;
    case (dir_q)
      2'd0: begin
        tgt3    = pos3 - 3'd1;
        illegal = (pos4 % ST4) == 4'd0;
      end
      2'd1: begin
        tgt3    = pos3 + 3'd1;
        illegal = ((pos4 % ST4) == (ST4 - 4'd1)) || (pos4 == (NS4 - 4'd1));
      end
      2'd2: begin
        tgt3    = pos3 - ST3;
        illegal = pos4 < ST4;
      end
      default: begin
        tgt3    = pos3 + ST3;
        illegal = (pos4 + ST4) > (NS4 - 4'd1);
      end
    endcase
    if (pos4 > (NS4 - 4'd1)) illegal = 1'b1;
  end

  function automatic logic [W-1:0] swap_slots(input logic [W-1:0] b,
                                               input logic [2:0]   p,
                                               input logic [2:0]   t);
    logic [W-1:0] r;
    r = b;
    r[W-1-4*int'(p) -: 4] = b[W-1-4*int'(t) -: 4];
    r[W-1-4*int'(t) -: 4] = b[W-1-4*int'(p) -: 4];
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir_q      <= 2'd0;
      tgt_q      <= 3'd0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.solved <= 1'b0;
      bus.src0   <= 4'd0;
      bus.src1   <= 4'd0;
      bus.we     <= 1'b0;
      bus.dst    <= 4'd0;
      bus.data   <= '0;
    end else begin
      bus.we   <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dir_q    <= bus.dir;
            bus.src0 <= R_BOARD;
            bus.src1 <= R_PLACE;
            bus.busy <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (illegal) begin
            bus.done <= 1'b1;
            bus.err  <= 1'b1;
            state    <= ERR;
          end else begin
            tgt_q    <= tgt3;
            bus.we   <= 1'b1;
            bus.dst  <= R_BOARD;
            bus.data <= swap_slots(bus.data0, pos3, tgt3);
            state    <= SWAP;
          end
        end
        SWAP: begin
          bus.we   <= 1'b1;
          bus.dst  <= R_PLACE;
          bus.data <= W'(tgt_q);
          bus.src0 <= R_CNT;
          state    <= WPOS;
        end
        WPOS: begin
          bus.we   <= 1'b1;
          bus.dst  <= R_CNT;
          bus.data <= bus.data0 + W'(1);
          bus.src0 <= R_BOARD;
          bus.src1 <= R_IDEAL;
          state    <= WCNT;
        end
        WCNT: begin
          // Board written in SWAP is already visible on data0 here.
          bus.we     <= 1'b1;
          bus.dst    <= R_COMP;
          bus.data   <= {{(W-1){1'b0}}, eq};
          bus.solved <= eq;
          state      <= CMP;
        end
        CMP: begin
          bus.done <= 1'b1;
          state    <= DONE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_exec.sv
// Randomised bench for move_exec: bench-side register file, tile-array reference model, per-cycle schedule checker.
module tb_move_exec;
  localparam int W = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  move_exec_if #(.W(W)) bus ();
  move_exec #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [W-1:0] rf [16];
  logic         pre_we = 1'b0;
  logic [3:0]   pre_addr = 4'd0;
  logic [W-1:0] pre_dat = '0;

  assign bus.data0 = rf[bus.src0];
  assign bus.data1 = rf[bus.src1];

  always @(posedge clk) begin
    if (bus.we) rf[bus.dst] <= bus.data;
    else if (pre_we) rf[pre_addr] <= pre_dat;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: expected register contents and solved flag.
  logic [W-1:0] m [16];
  bit           m_solved = 1'b0;

  typedef struct {
    bit           we;
    logic [3:0]   dst;
    logic [W-1:0] data;
    bit           done;
    bit           err;
    bit           busy;
  } cyc_t;
  cyc_t q[$];

  function automatic cyc_t mk(bit we, logic [3:0] dst, logic [W-1:0] data, bit done, bit err, bit busy);
    cyc_t c;
    c.we = we; c.dst = dst; c.data = data; c.done = done; c.err = err; c.busy = busy;
    return c;
  endfunction

  // Board as seven tiles, tile 0 leftmost.
  function automatic logic [W-1:0] model_swap(logic [W-1:0] board, int p, int t);
    logic [3:0]   nib [7];
    logic [3:0]   tmp;
    logic [W-1:0] nb;
    for (int i = 0; i < 7; i++) nib[i] = board[4*(6-i) +: 4];
    tmp = nib[p]; nib[p] = nib[t]; nib[t] = tmp;
    nb = '0;
    for (int i = 0; i < 7; i++) nb = (nb << 4) | W'(nib[i]);
    return nb;
  endfunction

  function automatic int move_target(int pos, logic [1:0] d);
    case (d)
      2'd0:    return pos - 1;
      2'd1:    return pos + 1;
      2'd2:    return pos - 3;
      default: return pos + 3;
    endcase
  endfunction

  function automatic bit move_legal(int pos, logic [1:0] d);
    int t;
    t = move_target(pos, d);
    if (pos > 6 || t < 0 || t > 6) return 1'b0;
    if (d < 2 && (t / 3) != (pos / 3)) return 1'b0;
    return 1'b1;
  endfunction

  always begin : cmp
    cyc_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("we", W'(bus.we), W'(e.we));
      check("busy", W'(bus.busy), W'(e.busy));
      check("done", W'(bus.done), W'(e.done));
      check("err", W'(bus.err), W'(e.err));
      if (e.we) begin
        check("dst", W'(bus.dst), W'(e.dst));
        check("wdata", bus.data, e.data);
      end
    end
  end

  task automatic set_reg(input logic [3:0] a, input logic [W-1:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_dat = v;
    @(negedge clk);
    pre_we = 1'b0;
    m[a] = v;
  endtask

  task automatic do_move(input logic [1:0] d);
    int           pos, t, len;
    bit           legal, eq;
    logic [W-1:0] nb;
    pos   = int'(m[2][2:0]);
    t     = move_target(pos, d);
    legal = move_legal(pos, d);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = d;
    q.push_back(mk(0, 4'd0, '0, 0, 0, 1));
    if (legal) begin
      nb = model_swap(m[0], pos, t);
      eq = (nb == m[1]);
      q.push_back(mk(1, 4'd0, nb, 0, 0, 1));
      q.push_back(mk(1, 4'd2, W'(t), 0, 0, 1));
      q.push_back(mk(1, 4'd7, m[7] + W'(1), 0, 0, 1));
      q.push_back(mk(1, 4'd9, W'(eq), 0, 0, 1));
      q.push_back(mk(0, 4'd0, '0, 1, 0, 1));
      m[0] = nb; m[2] = W'(t); m[7] = m[7] + W'(1); m[9] = W'(eq); m_solved = eq;
      len = 6;
    end else begin
      q.push_back(mk(0, 4'd0, '0, 1, 1, 1));
      len = 2;
    end
    q.push_back(mk(0, 4'd0, '0, 0, 0, 0));
    // Garbage on start/dir while busy must be ignored.
    repeat (len) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(0, 1));
      bus.dir   = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    check("schedule_drained", W'(q.size()), '0);
    q.delete();
    check("r0", rf[0], m[0]);
    check("r2", rf[2], m[2]);
    check("r7", rf[7], m[7]);
    check("r9", rf[9], m[9]);
    check("solved", W'(bus.solved), W'(m_solved));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]   d;
    int           r, p;
    logic [W-1:0] r9_keep;
    bus.start = 1'b0;
    bus.dir   = 2'd0;
    #1;
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_err", W'(bus.err), '0);
    check("rst_solved", W'(bus.solved), '0);
    check("rst_we", W'(bus.we), '0);
    check("rst_src0", W'(bus.src0), '0);
    check("rst_src1", W'(bus.src1), '0);
    check("rst_dst", W'(bus.dst), '0);
    check("rst_data", bus.data, '0);
    for (int i = 0; i < 16; i++) set_reg(4'(i), W'($urandom));
    @(negedge clk);
    rst_n = 1'b1;

    // T1
    set_reg(4'd0, 28'hADEB567); set_reg(4'd1, 28'h1234567);
    set_reg(4'd2, 28'd0); set_reg(4'd7, 28'd0);
    do_move(2'd1);
    check("t1_r0", rf[0], 28'hDAEB567);
    check("t1_r2", rf[2], 28'd1);
    check("t1_r7", rf[7], 28'd1);
    check("t1_r9", rf[9], 28'd0);

    // T2
    set_reg(4'd0, 28'hADEB567); set_reg(4'd2, 28'd0);
    do_move(2'd3);
    check("t2_r0", rf[0], 28'hBDEA567);
    check("t2_r2", rf[2], 28'd3);
    check("t2_r7", rf[7], 28'd2);

    // T4
    set_reg(4'd0, 28'h6579DAF); set_reg(4'd1, 28'h5679DAF); set_reg(4'd2, 28'd0);
    do_move(2'd1);
    check("t4_r0", rf[0], 28'h5679DAF);
    check("t4_r9", rf[9], 28'd1);
    check("t4_solved", W'(bus.solved), 28'd1);

    // T3: illegal moves leave everything, including solved, untouched.
    set_reg(4'd2, 28'd0);
    do_move(2'd0);
    do_move(2'd2);
    check("t3_r0", rf[0], 28'h5679DAF);
    check("t3_r2", rf[2], 28'd0);
    check("t3_r7", rf[7], 28'd3);
    check("t3_r9", rf[9], 28'd1);
    check("t3_solved", W'(bus.solved), 28'd1);

    // Edge blanks: right from slot 6, anything from slot 7.
    set_reg(4'd2, 28'd6); do_move(2'd1);
    set_reg(4'd2, 28'd7); do_move(2'd3);
    set_reg(4'd2, 28'd7); do_move(2'd0);

    // T5
    set_reg(4'd7, 28'hFFFFFFF); set_reg(4'd2, 28'd4);
    do_move(2'd0);
    check("t5_r7_wrap", rf[7], 28'd0);

    // T6: reset during the counter write.
    set_reg(4'd0, 28'hADEB567); set_reg(4'd2, 28'd0); set_reg(4'd7, 28'd5);
    r9_keep = rf[9];
    @(negedge clk);
    bus.start = 1'b1; bus.dir = 2'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("t6_in_wcnt_dst", W'(bus.dst), 28'd7);
    rst_n = 1'b0;
    #1;
    check("t6_we", W'(bus.we), '0);
    check("t6_busy", W'(bus.busy), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_r0", rf[0], 28'hDAEB567);
    check("t6_r2", rf[2], 28'd1);
    check("t6_r7", rf[7], 28'd5);
    check("t6_r9", rf[9], r9_keep);
    m[0] = 28'hDAEB567; m[2] = 28'd1; m[7] = 28'd5; m[9] = r9_keep; m_solved = 1'b0;
    do_move(2'd1);
    check("t6_after_r7", rf[7], 28'd6);
    check("t6_after_r0", rf[0], 28'hDEAB567);

    // Random moves.
    repeat (60) begin
      r = $urandom_range(0, 9);
      d = 2'($urandom_range(0, 3));
      if (r < 2) set_reg(4'd2, 28'($urandom_range(0, 7)));
      else if (r == 2) set_reg(4'd2, W'($urandom));
      else if (r == 3) set_reg(4'd0, W'($urandom));
      else if (r == 4) set_reg(4'd7, 28'hFFFFFFF - 28'($urandom_range(0, 1)));
      else if (r == 5) begin
        p = int'(m[2][2:0]);
        if (move_legal(p, d)) set_reg(4'd1, model_swap(m[0], p, move_target(p, d)));
      end
      do_move(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
